// File: rtl/seg_scan_if.sv
// seg_scan_if: load handshake and display bus between a controller and seg_scan.
//   i_load    - single-cycle load request (master -> slave)
//   i_value   - hex nibbles, digit k at [4k+3:4k], digit 0 rightmost
//   i_dp      - per-digit decimal point
//   i_blank   - per-digit blanking
//   o_seg     - segments {a,b,c,d,e,f,g,dp}, polarity set by the driver
//   o_an      - one-hot digit enable, polarity set by the driver
//   o_pending - a load is waiting for the frame boundary
//   o_ack     - one-cycle pulse when a load is committed
interface seg_scan_if #(
    parameter int DIGITS = 8
);
    logic                  i_load;
    logic [4*DIGITS-1:0]   i_value;
    logic [DIGITS-1:0]     i_dp;
    logic [DIGITS-1:0]     i_blank;
    logic [7:0]            o_seg;
    logic [DIGITS-1:0]     o_an;
    logic                  o_pending;
    logic                  o_ack;

    modport master (
        output i_load, i_value, i_dp, i_blank,
        input  o_seg, o_an, o_pending, o_ack
    );

    modport slave (
        input  i_load, i_value, i_dp, i_blank,
        output o_seg, o_an, o_pending, o_ack
    );
endinterface

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed seven-segment driver with frame-boundary load commit.
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - seg_scan_if.slave: load handshake in, segment/enable/pending/ack out
// Optional feature: define SEG_SCAN_LEADZERO_EN for leading-zero suppression.
module seg_scan #(
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = 1000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus
);
    localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0]     P_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [DW-1:0]     D_LAST  = DW'(DIGITS - 1);
    localparam logic [7:0]        SEG_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? '1 : '0;

    logic [PW-1:0]       presc;
    logic [DW-1:0]       idx;
    logic [4*DIGITS-1:0] sh_value, act_value;
    logic [DIGITS-1:0]   sh_dp, sh_blank, act_dp, act_blank;
    logic                pending, ack;
    logic [7:0]          seg_q;
    logic [DIGITS-1:0]   an_q;
    logic                presc_wrap, frame, commit;
    logic [3:0]          nib;
    logic                dp_bit, blank_bit, supp_bit;
    logic [DIGITS-1:0]   lz;
    logic [DIGITS-1:0]   onehot;
    logic [7:0]          lit;

    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 8'hFC;
            4'h1: return 8'h60;
            4'h2: return 8'hDA;
            4'h3: return 8'hF2;
            4'h4: return 8'h66;
            4'h5: return 8'hB6;
            4'h6: return 8'hBE;
            4'h7: return 8'hE0;
            4'h8: return 8'hFE;
            4'h9: return 8'hF6;
            4'hA: return 8'hEE;
            4'hB: return 8'h3E;
            4'hC: return 8'h9C;
            4'hD: return 8'h7A;
            4'hE: return 8'h9E;
            default: return 8'h8E;
        endcase
    endfunction

    assign presc_wrap = presc == P_LAST;
    assign frame      = presc_wrap && idx == D_LAST;
    // A load arriving on the boundary itself bypasses the shadow set.
    assign commit     = frame && (bus.i_load || pending);

`ifdef SEG_SCAN_LEADZERO_EN
    logic zero_above;
    // Scan from the most significant digit down; digit 0 is never suppressed.
    always_comb begin
        lz = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            zero_above = zero_above & (act_value[4*k +: 4] == 4'h0);
            lz[k] = zero_above;
        end
    end
`else
    assign lz = '0;
`endif

    always_comb begin
        nib       = 4'h0;
        dp_bit    = 1'b0;
        blank_bit = 1'b0;
        supp_bit  = 1'b0;
        onehot    = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == DW'(k)) begin
                nib       = act_value[4*k +: 4];
                dp_bit    = act_dp[k];
                blank_bit = act_blank[k];
                supp_bit  = lz[k];
                onehot[k] = 1'b1;
            end
        end
        // Explicit blanking kills dp too; suppressed leading zeros keep dp.
        lit = blank_bit ? 8'h00 : supp_bit ? {7'b0, dp_bit} : seg7(nib) | {7'b0, dp_bit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            idx       <= '0;
            sh_value  <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            act_value <= '0;
            act_dp    <= '0;
            act_blank <= '0;
            pending   <= 1'b0;
            ack       <= 1'b0;
            seg_q     <= SEG_OFF;
            an_q      <= AN_OFF;
        end else begin
            presc <= presc_wrap ? '0 : presc + 1'b1;
            if (presc_wrap)
                idx <= idx == D_LAST ? '0 : idx + 1'b1;
            if (bus.i_load) begin
                sh_value <= bus.i_value;
                sh_dp    <= bus.i_dp;
                sh_blank <= bus.i_blank;
            end
            if (commit) begin
                act_value <= bus.i_load ? bus.i_value : sh_value;
                act_dp    <= bus.i_load ? bus.i_dp    : sh_dp;
                act_blank <= bus.i_load ? bus.i_blank : sh_blank;
            end
            pending <= frame ? 1'b0 : pending | bus.i_load;
            ack     <= commit;
            seg_q   <= ACTIVE_LOW ? ~lit : lit;
            an_q    <= ACTIVE_LOW ? ~onehot : onehot;
        end
    end

    assign bus.o_seg     = seg_q;
    assign bus.o_an      = an_q;
    assign bus.o_pending = pending;
    assign bus.o_ack     = ack;
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: randomized self-checking bench for seg_scan against a cycle-count reference model.
module tb_seg_scan;
    localparam int D  = 4;
    localparam int SD = 4;
    localparam int FR = D * SD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    seg_scan_if #(.DIGITS(D)) bus();

    seg_scan #(.DIGITS(D), .SCAN_DIV(SD), .ACTIVE_LOW(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] lut [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                             8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

    int          n;
    logic [15:0] m_av, m_sv;
    logic [3:0]  m_ad, m_ab, m_sd, m_sb;
    logic        m_pend, exp_ack;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_an;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at n=%0d t=%0t", tag, got, exp, n, $time);
        end
    endtask

    function automatic logic [7:0] lit_of(input logic [15:0] v, input logic [3:0] dp,
                                          input logic [3:0] bl, input int k);
        logic [3:0] nb;
        logic [7:0] p;
        nb = 4'((v >> (4 * k)) & 16'hF);
        p  = lut[nb] | {7'b0, dp[k]};
`ifdef SEG_SCAN_LEADZERO_EN
        if (k > 0 && (v >> (4 * k)) == 16'h0) p = {7'b0, dp[k]};
`endif
        if (bl[k]) p = 8'h00;
        return p;
    endfunction

    task automatic model_reset();
        n = 0;
        m_av = '0; m_sv = '0; m_ad = '0; m_ab = '0; m_sd = '0; m_sb = '0;
        m_pend = 1'b0;
        exp_ack = 1'b0;
    endtask

    // One clock: drive inputs, advance the model across the edge, then compare.
    task automatic cycle(input logic ld, input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
        int  dig;
        bit  fb;
        bus.i_load  = ld;
        bus.i_value = v;
        bus.i_dp    = dp;
        bus.i_blank = bl;
        @(posedge clk);
        dig     = (n / SD) % D;
        fb      = (n % FR) == FR - 1;
        exp_seg = ~lit_of(m_av, m_ad, m_ab, dig);
        exp_an  = ~(4'b1 << dig);
        exp_ack = fb && (ld || m_pend);
        if (fb && ld) begin
            m_av = v; m_ad = dp; m_ab = bl;
        end else if (fb && m_pend) begin
            m_av = m_sv; m_ad = m_sd; m_ab = m_sb;
        end
        if (ld) begin
            m_sv = v; m_sd = dp; m_sb = bl;
        end
        m_pend = fb ? 1'b0 : (m_pend | ld);
        n++;
        #1;
        check("seg", bus.o_seg, exp_seg);
        check("an", bus.o_an, exp_an);
        check("ack", bus.o_ack, exp_ack);
        check("pending", bus.o_pending, m_pend);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cycle(1'b0, 16'h0, 4'h0, 4'h0);
    endtask

    task automatic idle_to(input int ph);
        while (n % FR != ph) cycle(1'b0, 16'h0, 4'h0, 4'h0);
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
        cycle(1'b1, v, dp, bl);
    endtask

    task automatic check_reset_state();
        check("rst_seg", bus.o_seg, 8'hFF);
        check("rst_an", bus.o_an, 4'hF);
        check("rst_ack", bus.o_ack, 1'b0);
        check("rst_pending", bus.o_pending, 1'b0);
    endtask

    initial begin
        bus.i_load = 1'b0; bus.i_value = '0; bus.i_dp = '0; bus.i_blank = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        rst_n = 1'b1;
        cycle(1'b0, 16'h0, 4'h0, 4'h0);
        check("first_seg", bus.o_seg, 8'h03);
        check("first_an", bus.o_an, 4'hE);
        idle(2 * FR);

        idle_to(5);
        load(16'hAB9C, 4'h0, 4'h0);
        idle(2 * FR);

        idle_to(2);
        load($urandom_range(16'hFFFF), 4'b0010, 4'b0100);
        idle(2 * FR);

        idle_to(3);
        load(16'h1234, 4'h0, 4'h0);
        idle(4);
        load(16'h5678, 4'b1000, 4'h0);
        idle(2 * FR);

        idle_to(FR - 1);
        load(16'hCAFE, 4'b0101, 4'b0000);
        idle(FR + 3);

        load(16'h0050, 4'h0, 4'h0);
        idle(2 * FR);
        load(16'h0000, 4'b0100, 4'h0);
        idle(2 * FR);
        load(16'h0000, 4'h0, 4'h0);
        idle(2 * FR);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0)
                load(16'($urandom), 4'($urandom), 4'($urandom_range(3) == 0 ? $urandom : 0));
            else
                idle(1);
        end

        idle_to(2);
        load(16'h9999, 4'hF, 4'h0);
        idle(2);
        check("pend_before_rst", bus.o_pending, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_state();
        @(posedge clk);
        #1;
        check_reset_state();
        rst_n = 1'b1;
        cycle(1'b0, 16'h0, 4'h0, 4'h0);
        check("rel_seg", bus.o_seg, 8'h03);
        check("rel_an", bus.o_an, 4'hE);
        idle(2 * FR);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg_scan.md
# seg_scan

Parametrised, time-multiplexed seven-segment display driver for the board's multi-digit LED display. It holds a DIGITS-wide hexadecimal value and scans one digit at a time, producing segment and digit-enable outputs with configurable polarity. It decodes 0–F with per-digit decimal-point and blanking controls. New values are accepted through a load handshake and take effect only at a frame boundary, so the display never shows a torn value.

## Interface
- DIGITS, 8: number of digits scanned; ≥ 1.
- SCAN_DIV, 1000: clock cycles each digit is held; ≥ 1.
- ACTIVE_LOW, 1: 1 = segments and digit enables are lit when 0; 0 = lit when 1.

- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_load  in  1  single-cycle request to load i_value, i_dp and i_blank.
- i_value  in  4*DIGITS  hex nibbles; digit k is bits [4k+3:4k]; digit 0 is rightmost.
- i_dp  in  DIGITS  decimal point lit for digit k when bit k = 1.
- i_blank  in  DIGITS  all segments of digit k off when bit k = 1.
- o_seg  out  8  segments {a,b,c,d,e,f,g,dp} in bits [7:0]; bit 7 = a, bit 0 = dp.
- o_an  out  DIGITS  one-hot digit enable; bit k selects digit k.
- o_pending  out  1  a load is waiting for the frame boundary.
- o_ack  out  1  one-cycle pulse when a load is committed to the display.

## Operation
- Lit-segment patterns, before polarity is applied:
  - 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0
  - 8=FE, 9=F6, A=EE, b=3E, C=9C, d=7A, E=9E, F=8E
  - The dp bit (bit 0) is taken from the digit's dp flag.
- Blanked digit: pattern 00, including dp. Its enable in o_an is still driven.
- Polarity: if ACTIVE_LOW=1, o_seg and o_an are the bitwise inverse of the lit pattern and the one-hot enable.
- Registers:
  - Prescaler: counts 0..SCAN_DIV-1.
  - Digit index: counts 0..DIGITS-1.
  - Shadow set: value, dp and blank.
  - Active set: value, dp and blank.
  - Pending flag.
- Scan sequence:
  - When the prescaler is at SCAN_DIV-1, it wraps to 0 and the digit index advances.
  - The digit index wraps from DIGITS-1 to 0. This wrap is the frame boundary.
- Load handshake:
  - i_load=1 writes the shadow set and sets pending.
  - A second load before commit overwrites the shadow set; the last load wins, and only one ack is issued.
  - At the frame boundary with pending=1, shadow is copied to active, pending clears, and o_ack pulses in the next cycle.
  - i_load in the same cycle as the frame boundary commits that cycle's inputs directly. Pending stays 0 and ack still pulses.
- Reset mid-operation:
  - All state clears immediately.
  - A pending load is discarded with no ack.

## Timing
- Reset values:
  - Prescaler 0, digit index 0, active and shadow sets 0, pending 0, o_ack 0.
  - o_seg and o_an all unlit: all-ones if ACTIVE_LOW=1, all-zeros if ACTIVE_LOW=0.
- o_seg and o_an are registered. They reflect the digit index and active set of the previous cycle, giving 1-cycle latency.
- The first lit output appears in the first clock after rst_n deasserts: digit 0 showing 0.
- o_pending is a direct register output and rises in the cycle after i_load.
- Each digit is displayed for exactly SCAN_DIV cycles, so a frame is DIGITS*SCAN_DIV cycles.
- Load-to-ack latency is at most one frame plus 1 cycle.
- Edge cases:
  - SCAN_DIV=1: the digit advances every cycle.
  - DIGITS=1: every prescaler wrap is a frame boundary.

## Configuration
- SEG_SCAN_LEADZERO_EN defined: leading-zero suppression on the active set.
  - Digit k (k > 0) is blanked when its nibble and every higher nibble are 0.
  - Digit 0 is never suppressed.
  - A suppressed digit still shows dp if its dp flag is set.
  - i_blank also applies (OR).
- Not defined: only i_blank blanks digits; zeros are always displayed.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1.
- Reset:
  - Stimulus: hold rst_n=0.
  - Required: o_seg=FF, o_an=F, o_ack=0.
  - Stimulus: release rst_n.
  - Required: next cycle o_seg=03 (~FC), o_an=E.
  - Required: o_an steps E,D,B,7 every 4 cycles, then back to E.
- Hex decode:
  - Stimulus: load i_value=16'hAb9C.
  - Required after commit: o_seg cycles ~9C=63, ~F6=09, ~3E=C1, ~EE=11 on o_an E,D,B,7.
- DP and blank:
  - Stimulus: load i_dp=4'b0010, i_blank=4'b0100.
  - Required: digit 1 o_seg bit 0 = 0 (dp lit); digit 2 o_seg=FF.
- Load timing:
  - Stimulus: i_load mid-frame.
  - Required: o_pending=1 until the frame boundary; o_ack exactly one pulse; display unchanged before the boundary.
  - Stimulus: two loads before the boundary.
  - Required: the second value is shown; one ack.
  - Stimulus: i_load on the boundary cycle.
  - Required: ack next cycle, o_pending never rises.
- Mid-operation reset:
  - Stimulus: rst_n=0 while o_pending=1.
  - Required: pending cleared, no ack, value 0 displayed after release.
- Leading zeros (SEG_SCAN_LEADZERO_EN defined):
  - Stimulus: load 16'h0050.
  - Required: digits 3 and 2 o_seg=FF; digit 1 shows 5 (~B6=49); digit 0 shows 0 (03).
  - Stimulus: load 16'h0000.
  - Required: only digit 0 lit.
